data_mem_responder: RTL
=======================

# data_mem_responder

Word-organised data memory that answers load/store requests from the CPU datapath over a req/ack handshake, with a programmable number of wait states. It is the responder end of the CPU's data-access path: the datapath issues address, write data and byte enables, and this block holds the storage and returns read data or an error. Requests are accepted one at a time and every accepted request produces exactly one ack.

## Interface
- DEPTH, 128: number of 32-bit words; valid word index 0..DEPTH-1.
- WAIT, 2: wait-state cycles between acceptance and response; legal range 0..15.
- clk_i  in  1  single clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request valid.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address; word index = addr_i[31:2].
- wdata_i  in  32  store data.
- be_i  in  4  byte enables for stores; bit n selects bits [8n+7:8n].
- rdata_o  out  32  load data, valid while ack_o=1, held until next ack.
- ack_o  out  1  one-cycle response pulse.
- err_o  out  1  error flag, qualified by ack_o.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- Reset (rst_i=1 at an edge): state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0, busy_o=0, all DEPTH words cleared to 0. Reset wins over any other event in the same cycle, including mid-WAIT and RESP; the in-flight request is dropped with no ack and no write.
- States: IDLE, WAIT, RESP.
- IDLE: if req_i=1 at an edge, capture we_i, addr_i, wdata_i, be_i into internal registers; go to WAIT with counter=WAIT-1 if WAIT>0, else go directly to RESP (access performed on that same edge). Inputs after capture are ignored.
- WAIT: counter decrements each edge; at the edge where counter=0, perform the access and go to RESP.
- Access (on the edge entering RESP):
  - Error if captured addr[1:0]!=0 or addr[31:2]>=DEPTH: no memory change, rdata_o<=0, err_o<=1.
  - Store: for each n with be[n]=1, byte n of word addr[31:2] <= wdata byte n; be=4'b0000 is a legal no-op store; rdata_o unchanged; err_o<=0.
  - Load: rdata_o<=mem[addr[31:2]]; err_o<=0.
- RESP: ack_o=1 for exactly this cycle; next edge returns to IDLE unconditionally. req_i in the RESP cycle is ignored.
- Requester rule: hold req_i and fields stable until ack_o, then deassert in the cycle after ack. If req_i is still 1 in IDLE after RESP, it is a new request.
- ack_o, err_o, rdata_o, busy_o are all registered outputs.

## Timing
- Capture edge E0. ack_o high in the cycle after edge E0+WAIT; load latency = WAIT+1 cycles from E0 to ack.
- WAIT=0: ack_o high the cycle after E0; busy_o high only in RESP.
- Back-to-back throughput: one request per WAIT+2 cycles (RESP to IDLE costs one cycle).
- Store data visible to a load accepted in any later IDLE cycle; no read-during-write hazard, as only one access is ever in flight.
- err_o and rdata_o of a prior response remain on the outputs while ack_o=0; consumers qualify them with ack_o.

## Test plan
- Reset then load: rst_i for 2 cycles, load addr 0x00000010 with WAIT=2 -> ack_o exactly 3 cycles after capture, rdata_o=0x00000000, err_o=0, busy_o high for 3 cycles.
- Store/load round trip: store 0xDEADBEEF be=4'b1111 to 0x00000008, then load 0x08 -> rdata_o=0xDEADBEEF; a partial store of 0x00001200 with be=4'b0010 to the same address, then load -> 0xDEAD12EF.
- Errors: load 0x00000006 -> ack with err_o=1, rdata_o=0; store to 0x00000200 (word 128, DEPTH=128) -> err_o=1, and a load of 0x00000000 still returns its old value.
- Held request: req_i kept high across the ack for 0x04 -> exactly two acks, separated by WAIT+2 cycles; input fields changed during WAIT do not affect the captured access.
- Reset mid-operation: store 0x12345678 to 0x0C, rst_i=1 during the second WAIT cycle -> no ack, busy_o=0 next cycle, and a subsequent load of 0x0C returns 0.
- WAIT=0 build: load 0x00 -> ack_o in the cycle after capture; a store followed immediately by a load of the same address returns the stored word.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering CPU load/store requests over req/ack.
// Latency: ack_o is high in the cycle after edge E0+WAIT, where E0 is the capture edge (WAIT+1 cycles).
// Backpressure: one request in flight; req_i is sampled only in IDLE, so one request per WAIT+2 cycles.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (also clears the whole memory)
//   req_i, we_i        request valid, 1 = store / 0 = load
//   addr_i             byte address, word index = addr_i[31:2]
//   wdata_i, be_i      store data and per-byte enables
//   rdata_o            load data, held until the next load/error response
//   ack_o              one-cycle response pulse
//   err_o              misaligned or out-of-range access, qualified by ack_o
//   busy_o             high whenever the responder is not idle
module data_mem_responder #(
   parameter int DEPTH = 128,
   parameter int WAIT  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [3:0]  WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;

   // Request fields captured at acceptance; later input changes are ignored.
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic [31:0] mem [DEPTH];

   // Access operands. With WAIT=0 the access happens on the capture edge itself,
   // so the live inputs are used instead of the (not yet loaded) capture registers.
   logic          acc_go;
   logic          use_in;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic          acc_err;
   logic [AW-1:0] acc_idx;

   always_comb begin
      state_nxt = state;
      acc_go    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_i) begin
               if (WAIT == 0) begin
                  state_nxt = ST_RESP;
                  acc_go    = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = ST_RESP;
               acc_go    = 1'b1;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      use_in    = (state == ST_IDLE);
      acc_we    = use_in ? we_i    : we_q;
      acc_addr  = use_in ? addr_i  : addr_q;
      acc_wdata = use_in ? wdata_i : wdata_q;
      acc_be    = use_in ? be_i    : be_q;
      acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
      acc_idx   = acc_addr[AW+1:2];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= 32'd0;
         busy_o  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else begin
         state  <= state_nxt;
         ack_o  <= acc_go;
         busy_o <= (state_nxt != ST_IDLE);

         if (state == ST_IDLE && req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt     <= WAIT_M1;
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (acc_go) begin
            if (acc_err) begin
               rdata_o <= 32'd0;
               err_o   <= 1'b1;
            end else if (acc_we) begin
               // Stores leave rdata_o alone; be=0 is a legal no-op.
               for (int n = 0; n < 4; n++) begin
                  if (acc_be[n]) begin
                     mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
                  end
               end
               err_o <= 1'b0;
            end else begin
               rdata_o <= mem[acc_idx];
               err_o   <= 1'b0;
            end
         end
      end
   end

endmodule
